// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared FSM state enum and default widths for add_chunk_seq
package add_seq_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} add_seq_state_t;
  localparam int ADD_SEQ_WIDTH = 32;
  localparam int ADD_SEQ_CHUNK_W = 8;
endpackage

// File: rtl/add_chunk_seq_adder.sv
// adder: WIDTH-bit ripple-carry adder slice with carry in/out
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
endmodule

// File: rtl/add_chunk_seq.sv
// add_chunk_seq: WIDTH-bit add over NCHUNK cycles on one CHUNK_W adder; ADD_SEQ_SUB_EN adds req_sub (A-B)
module add_chunk_seq import add_seq_pkg::*; #(
  parameter int WIDTH = ADD_SEQ_WIDTH,
  parameter int CHUNK_W = ADD_SEQ_CHUNK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
`ifdef ADD_SEQ_SUB_EN
  input  logic             req_sub,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             busy
);
  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IW = $clog2(NCHUNK);
  if (WIDTH % CHUNK_W != 0 || NCHUNK < 2) begin : g_bad_cfg
    $error("add_chunk_seq: WIDTH must be a multiple of CHUNK_W with at least two chunks");
  end
  add_seq_state_t state, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, b_in;
  logic [IW-1:0] idx;
  logic [CHUNK_W-1:0] s_sum;
  logic carry_q, cout_q, c_in, s_cout, accept, last;
`ifdef ADD_SEQ_SUB_EN
  assign b_in = req_sub ? ~req_b : req_b;
  assign c_in = req_sub | req_cin;
`else
  assign b_in = req_b;
  assign c_in = req_cin;
`endif
  adder #(.WIDTH(CHUNK_W)) u_adder (
    .a(a_q[CHUNK_W*int'(idx) +: CHUNK_W]),
    .b(b_q[CHUNK_W*int'(idx) +: CHUNK_W]),
    .cin(carry_q),
    .sum(s_sum),
    .cout(s_cout)
  );
  always_comb begin
    req_ready = state == IDLE || (state == DONE && resp_ready);
    accept = req_valid && req_ready;
    last = idx == IW'(NCHUNK - 1);
    state_d = state == IDLE ? (accept ? BUSY : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : accept ? BUSY : resp_ready ? IDLE : DONE;
  end
  assign resp_valid = state == DONE;
  assign busy = state != IDLE;
  assign resp_sum = sum_q;
  assign resp_cout = cout_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      carry_q <= 1'b0;
      sum_q <= '0;
      cout_q <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q <= req_a;
        b_q <= b_in;
        carry_q <= c_in;
        idx <= '0;
      end else if (state == BUSY) begin
        sum_q[CHUNK_W*int'(idx) +: CHUNK_W] <= s_sum;
        carry_q <= s_cout;
        idx <= last ? '0 : idx + 1'b1;
        if (last) cout_q <= s_cout;
      end
    end
  end
endmodule

// File: tb/tb_add_chunk_seq.sv
// tb_add_chunk_seq: vector table plus handshake corner cases, scoreboard-checked
module tb_add_chunk_seq;
  localparam int N = 4;
  typedef struct {logic [31:0] a; logic [31:0] b; logic cin; logic sub; logic [31:0] sum; logic cout;} vec_t;
  typedef struct {logic [31:0] sum; logic cout; int acc;} exp_t;
  logic clk = 0, rst_n = 0, req_valid = 0, req_cin = 0, resp_ready = 1;
  logic [31:0] req_a = 0, req_b = 0, exp_sum = 0;
  logic exp_cout = 0, rv_prev = 0;
`ifdef ADD_SEQ_SUB_EN
  logic req_sub = 0;
`endif
  logic req_ready, resp_valid, resp_cout, busy;
  logic [31:0] resp_sum;
  exp_t q[$];
  int cyc = 0, total = 0, passed = 0, last_acc = 0;
  add_chunk_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef ADD_SEQ_SUB_EN
    .req_sub(req_sub),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_sum(resp_sum),
    .resp_cout(resp_cout), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // scoreboard: push on accept, pop and compare on response handshake
  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      if (resp_valid && !rv_prev && q.size() > 0) chk("latency", 64'(cyc - q[0].acc), 64'(N));
      if (resp_valid && resp_ready) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_resp: got sum %0h with no pending request", resp_sum);
        end else begin
          chk("sum", 64'(resp_sum), 64'(q[0].sum));
          chk("cout", 64'(resp_cout), 64'(q[0].cout));
          void'(q.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        q.push_back(exp_t'{exp_sum, exp_cout, cyc + 1});
        last_acc = cyc + 1;
      end
    end
    rv_prev = resp_valid;
  end
  task automatic accept_op(logic [31:0] a, logic [31:0] b, logic cin, logic [31:0] es, logic ec);
    req_a = a;
    req_b = b;
    req_cin = cin;
    exp_sum = es;
    exp_cout = ec;
    req_valid = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    total++;
    $display("FAIL accept_timeout: req_ready stayed 0");
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      $display("FAIL resp_timeout: %0d responses outstanding", q.size());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t v[$];
    logic [31:0] ra, rb, rs;
    logic rc, rco;
    int a1, nvalid;
    v.push_back(vec_t'{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1});
    v.push_back(vec_t'{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0});
    v.push_back(vec_t'{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0});
    v.push_back(vec_t'{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1});
    v.push_back(vec_t'{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0});
    v.push_back(vec_t'{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0});
    v.push_back(vec_t'{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1});
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1));
      {rco, rs} = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      v.push_back(vec_t'{ra, rb, rc, 1'b0, rs, rco});
    end
`ifdef ADD_SEQ_SUB_EN
    v.push_back(vec_t'{32'd5, 32'd3, 1'b0, 1'b1, 32'h00000002, 1'b1});
    v.push_back(vec_t'{32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0});
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_sum", 64'(resp_sum), 64'd0);
    chk("rst_resp_cout", 64'(resp_cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    foreach (v[i]) begin
`ifdef ADD_SEQ_SUB_EN
      req_sub = v[i].sub;
`endif
      accept_op(v[i].a, v[i].b, v[i].cin, v[i].sum, v[i].cout);
      req_valid = 0;
      wait_empty();
    end
`ifdef ADD_SEQ_SUB_EN
    req_sub = 0;
`endif
    // backpressure: response must hold for three stalled cycles
    resp_ready = 0;
    accept_op(32'hDEADBEEF, 32'h01234567, 1'b0, 32'hDFD10456, 1'b0);
    req_valid = 0;
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_sum", 64'(resp_sum), 64'hDFD10456);
      chk("bp_cout", 64'(resp_cout), 64'd0);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd1);
      if (i < 2) @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1;
    wait_empty();
    @(negedge clk);
    chk("bp_released_valid", 64'(resp_valid), 64'd0);
    chk("bp_released_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    accept_op(32'd1, 32'd2, 1'b0, 32'd3, 1'b0);
    a1 = last_acc;
    accept_op(32'h80000000, 32'h80000000, 1'b0, 32'd0, 1'b1);
    chk("b2b_spacing", 64'(last_acc - a1), 64'(N + 1));
    req_valid = 0;
    wait_empty();
    // reset while idx==2: the operation must vanish
    accept_op(32'hAAAA5555, 32'h12345678, 1'b0, 32'hBCDEABCD, 1'b0);
    req_valid = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    chk("abort_resp_valid", 64'(resp_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    nvalid = 0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) nvalid++;
    end
    chk("abort_no_resp", 64'(nvalid), 64'd0);
    @(posedge clk);
    #1;
    accept_op(32'd7, 32'd8, 1'b1, 32'd16, 1'b0);
    req_valid = 0;
    wait_empty();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
